hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

- Generates the forward selectors `fa_mux` and `fb_mux`, the load-use stall and the bubble for the execute stage.
- Sits beside decode and keeps its own shadow of destination registers in flight through EX, MEM and WB.
- Registers its selector codes so they are valid during the cycle the consuming instruction occupies EX.
- Accepts the execute-stage flush so squashed instructions never become forwarding sources.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register address width.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clock`  in  1  single core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `id_valid_ip`  in  1  decode holds a real instruction.
- `id_rs1_addr_ip`, `id_rs2_addr_ip`  in  REG_ADDR_W  source registers.
- `id_rs1_used_ip`, `id_rs2_used_ip`  in  1  source actually read by this instruction.
- `id_rd_addr_ip`  in  REG_ADDR_W  destination register.
- `id_rd_write_ip`  in  1  instruction writes `rd`.
- `id_is_load_ip`  in  1  instruction is a load; data is available only at WB.
- `flush_ip`  in  1  execute-stage redirect; squashes the instructions in fetch and decode.
- `fa_mux_op`, `fb_mux_op`  out  forward_mux_code  registered selectors for EX operands A and B.
- `stall_op`  out  1  combinational; holds the PC and the IF/ID register this cycle.
- `bubble_op`  out  1  registered; the instruction now in EX is a bubble, so EX must suppress ALU, LSU and writeback enables.
- `stall_count_op`, `flush_count_op`  out  CNT_W  saturating event counters.

## Operation
Shadow state:
- Three entries `{valid, rd, is_load}`: `sh_ex`, `sh_mem`, `sh_wb`.
- Every cycle they shift `sh_ex`→`sh_mem`→`sh_wb`.
- `sh_ex` loads from decode when `id_valid_ip & id_rd_write_ip & (id_rd_addr_ip != 0)` and neither `stall_op` nor `flush_ip` is asserted. Otherwise `sh_ex.valid` is 0.

Stall decision:
- `stall_op = id_valid_ip & !flush_ip & sh_ex.valid & sh_ex.is_load`, and a used source equals `sh_ex.rd`.
- This is the load-use case and stalls for exactly one cycle.
- On the next cycle the load sits in `sh_mem` and no longer matches `sh_ex`.

Selector decision, per operand (the decode-time comparison):
- Source unused, or address 0 → `NO_FORWARD_SELECT`.
- Match on `sh_ex` (producer one ahead, non-load) → `EX_RESULT_SELECT`; execute reads the EX/MEM ALU result.
- Otherwise, match on `sh_mem` (producer two ahead, ALU or load) → `WB_RESULT_SELECT`; execute reads the writeback data.
- Otherwise → `NO_FORWARD_SELECT`. A `sh_wb` match is covered by register-file write-through.
- Youngest producer wins when several entries match.
- `MEM_RESULT_SELECT` is never emitted.

Selector and bubble registers:
- The codes are registered into `fa_mux_op`/`fb_mux_op` on the same edge that moves the instruction into EX.
- If `stall_op` or `flush_ip` is set, or `id_valid_ip` is low, the codes register as `NO_FORWARD_SELECT` and `bubble_op` registers 1.
- Otherwise `bubble_op` registers 0.

Flush:
- Has priority over stall: when `flush_ip` is asserted, `stall_op` is forced 0.
- Entries already in `sh_ex`, `sh_mem` and `sh_wb` are older than the redirecting instruction; they keep shifting and are not cleared.

Counters:
- `stall_count_op` increments on each cycle `stall_op` is 1.
- `flush_count_op` increments on each cycle `flush_ip` is 1.
- Both saturate at all-ones.

## Timing
Reset values:
- All shadow `valid` = 0.
- `fa_mux_op`/`fb_mux_op` = `NO_FORWARD_SELECT`.
- `bubble_op` = 1, `stall_op` = 0, counters = 0.
- Reset deasserting mid-stream leaves the unit with no in-flight producers.

Latency and timing rules:
- Selector latency is 1 cycle: the decode-cycle comparison becomes the register output in the EX cycle.
- `stall_op` has zero latency and depends only on current inputs and `sh_ex`.
- Load-use hazard: exactly one stall cycle, then selector `WB_RESULT_SELECT`.
- A load two ahead needs no stall.
- Back-to-back flushes each squash. A flush during a stall cycle cancels the stall, and the load still advances.

## Structure
Shared core package:
- `forward_mux_code`: existing enum; `NO_FORWARD_SELECT` is the default.
- A `fwd_shadow_t` struct `{valid, rd, is_load}`.

Sub-module:
- `fwd_select`: one per operand, combinational. Takes `(addr, used, sh_ex, sh_mem)` and returns `{code, load_hazard}`. It is instantiated twice.

## Test plan
- `add x5` then `sub` using `x5` as rs1 → `fa_mux_op`=`EX_RESULT_SELECT` in `sub`'s EX cycle, no stall.
- `add x5`, unrelated instruction, then `or` using rs2=`x5` → `fb_mux_op`=`WB_RESULT_SELECT`.
- `lw x7` then `add` using `x7` as rs1 → `stall_op`=1 for one cycle, `bubble_op`=1 in the next EX cycle, then `fa_mux_op`=`WB_RESULT_SELECT`, `stall_count_op`=1.
- Writes to `x0` followed by reads of `x0` → both selectors `NO_FORWARD_SELECT`. Two producers of `x3` back-to-back → youngest wins: `EX_RESULT_SELECT`.
- `flush_ip` during a load-use stall → `stall_op`=0, next `bubble_op`=1, the squashed instruction never forwards, `flush_count_op`=1.
- `reset` driven low asynchronously mid-sequence → outputs go immediately to their reset values; the first post-reset dependent instruction sees `NO_FORWARD_SELECT`.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the decode-side hazard and forwarding unit: operand selector codes and the
// shadow entry that tracks a destination register in flight.
package hazard_forward_unit_pkg;

    // The shadow rd field is fixed at this width; REG_ADDR_W must match it.
    localparam int unsigned ShadowRdW = 5;

    typedef enum logic [1:0] {
        NO_FORWARD_SELECT  = 2'd0,
        EX_RESULT_SELECT   = 2'd1,
        MEM_RESULT_SELECT  = 2'd2,
        WB_RESULT_SELECT   = 2'd3
    } forward_mux_code;

    typedef struct packed {
        logic                 valid;
        logic [ShadowRdW-1:0] rd;
        logic                 is_load;
    } fwd_shadow_t;

    localparam fwd_shadow_t ShadowEmpty = '0;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-to-hazard-unit bundle: master is the pipeline side, slave is the hazard unit.
interface hazard_forward_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    import hazard_forward_unit_pkg::*;

    logic                  id_valid_ip;
    logic [REG_ADDR_W-1:0] id_rs1_addr_ip;
    logic [REG_ADDR_W-1:0] id_rs2_addr_ip;
    logic                  id_rs1_used_ip;
    logic                  id_rs2_used_ip;
    logic [REG_ADDR_W-1:0] id_rd_addr_ip;
    logic                  id_rd_write_ip;
    logic                  id_is_load_ip;
    logic                  flush_ip;
    forward_mux_code       fa_mux_op;
    forward_mux_code       fb_mux_op;
    logic                  stall_op;
    logic                  bubble_op;
    logic [CNT_W-1:0]      stall_count_op;
    logic [CNT_W-1:0]      flush_count_op;

    modport master (
        output id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip, id_rs2_used_ip,
               id_rd_addr_ip, id_rd_write_ip, id_is_load_ip, flush_ip,
        input  fa_mux_op, fb_mux_op, stall_op, bubble_op, stall_count_op, flush_count_op
    );

    modport slave (
        input  id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip, id_rs2_used_ip,
               id_rd_addr_ip, id_rd_write_ip, id_is_load_ip, flush_ip,
        output fa_mux_op, fb_mux_op, stall_op, bubble_op, stall_count_op, flush_count_op
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forward selection against the EX and MEM shadow entries; flags a load-use hit.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
(
    input  logic [ShadowRdW-1:0] addr_i,
    input  logic                 used_i,
    input  fwd_shadow_t          sh_ex_i,
    input  fwd_shadow_t          sh_mem_i,
    output forward_mux_code      code_o,
    output logic                 load_hazard_o
);

    logic src_live;
    logic hit_ex;
    logic hit_mem;

    // ALU and load results both reach execute through writeback data from MEM.
    logic unused_mem_load;
    assign unused_mem_load = sh_mem_i.is_load;

    assign src_live = used_i && (addr_i != '0);
    assign hit_ex   = src_live && sh_ex_i.valid && (sh_ex_i.rd == addr_i);
    assign hit_mem  = src_live && sh_mem_i.valid && (sh_mem_i.rd == addr_i);

    always_comb begin
        code_o        = NO_FORWARD_SELECT;
        load_hazard_o = 1'b0;
        // The youngest producer shadows any older match, even when it is a stalling load.
        if (hit_ex) begin
            if (sh_ex_i.is_load) begin
                load_hazard_o = 1'b1;
            end else begin
                code_o = EX_RESULT_SELECT;
            end
        end else if (hit_mem) begin
            code_o = WB_RESULT_SELECT;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: shadows in-flight destinations, raises load-use stalls and registers
// the EX operand forward selectors and bubble flag.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = ShadowRdW,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    hazard_forward_unit_if.slave  bus
);

    fwd_shadow_t          sh_ex_q, sh_mem_q, sh_wb_q, sh_ex_d;
    forward_mux_code      fa_code, fb_code, fa_q, fb_q, fa_d, fb_d;
    logic                 haz_a, haz_b, stall, bubble_q, bubble_d, issue;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;

    // sh_wb matches are satisfied by register-file write-through, so it is never consulted.
    logic unused_sh_wb;
    assign unused_sh_wb = ^sh_wb_q;

    assign id_rd = bus.id_rd_addr_ip;

    hazard_forward_unit_fwd_select u_fwd_select_a (
        .addr_i        (bus.id_rs1_addr_ip),
        .used_i        (bus.id_rs1_used_ip),
        .sh_ex_i       (sh_ex_q),
        .sh_mem_i      (sh_mem_q),
        .code_o        (fa_code),
        .load_hazard_o (haz_a)
    );

    hazard_forward_unit_fwd_select u_fwd_select_b (
        .addr_i        (bus.id_rs2_addr_ip),
        .used_i        (bus.id_rs2_used_ip),
        .sh_ex_i       (sh_ex_q),
        .sh_mem_i      (sh_mem_q),
        .code_o        (fb_code),
        .load_hazard_o (haz_b)
    );

    assign stall = bus.id_valid_ip && !bus.flush_ip && (haz_a || haz_b);
    assign issue = bus.id_valid_ip && !stall && !bus.flush_ip;

    always_comb begin
        sh_ex_d         = ShadowEmpty;
        sh_ex_d.valid   = issue && bus.id_rd_write_ip && (id_rd != '0);
        sh_ex_d.rd      = id_rd;
        sh_ex_d.is_load = bus.id_is_load_ip;
        fa_d            = issue ? fa_code : NO_FORWARD_SELECT;
        fb_d            = issue ? fb_code : NO_FORWARD_SELECT;
        bubble_d        = !issue;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_ex_q     <= ShadowEmpty;
            sh_mem_q    <= ShadowEmpty;
            sh_wb_q     <= ShadowEmpty;
            fa_q        <= NO_FORWARD_SELECT;
            fb_q        <= NO_FORWARD_SELECT;
            bubble_q    <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sh_ex_q  <= sh_ex_d;
            sh_mem_q <= sh_ex_q;
            sh_wb_q  <= sh_mem_q;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            bubble_q <= bubble_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush_ip && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fa_mux_op      = fa_q;
    assign bus.fb_mux_op      = fb_q;
    assign bus.stall_op       = stall;
    assign bus.bubble_op      = bubble_q;
    assign bus.stall_count_op = stall_cnt_q;
    assign bus.flush_count_op = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding distances, load-use stall, x0, flush and
// asynchronous reset, each checked against hand-computed values.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic fl);
        bus.id_valid_ip    = v;
        bus.id_rs1_addr_ip = rs1;
        bus.id_rs1_used_ip = u1;
        bus.id_rs2_addr_ip = rs2;
        bus.id_rs2_used_ip = u2;
        bus.id_rd_addr_ip  = rd;
        bus.id_rd_write_ip = wr;
        bus.id_is_load_ip  = ld;
        bus.flush_ip       = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("rst_fb", bus.fb_mux_op, NO_FORWARD_SELECT);
        check("rst_bubble", bus.bubble_op, 1);
        check("rst_stall", bus.stall_op, 0);
        check("rst_stall_cnt", bus.stall_count_op, 0);
        check("rst_flush_cnt", bus.flush_count_op, 0);
        reset = 1'b1;
        tick();

        // add x5 ; sub x8, x5, x6
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        check("add_bubble", bus.bubble_op, 0);
        drive(1, 5, 1, 6, 1, 8, 1, 0, 0);
        #1 check("ex_fwd_stall", bus.stall_op, 0);
        tick();
        check("ex_fwd_fa", bus.fa_mux_op, EX_RESULT_SELECT);
        check("ex_fwd_fb", bus.fb_mux_op, NO_FORWARD_SELECT);

        // add x5 ; add x9, x1, x2 ; or x13, x1, x5
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 1, 1, 2, 1, 9, 1, 0, 0);
        tick();
        drive(1, 1, 1, 5, 1, 13, 1, 0, 0);
        tick();
        check("wb_fwd_fb", bus.fb_mux_op, WB_RESULT_SELECT);
        check("wb_fwd_fa", bus.fa_mux_op, NO_FORWARD_SELECT);

        // lw x7, 0(x2) ; add x14, x7, x0
        drive(1, 2, 1, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 1, 0, 1, 14, 1, 0, 0);
        #1 check("lu_stall", bus.stall_op, 1);
        tick();
        check("lu_bubble", bus.bubble_op, 1);
        check("lu_bubble_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        #1 check("lu_stall_released", bus.stall_op, 0);
        tick();
        check("lu_fa", bus.fa_mux_op, WB_RESULT_SELECT);
        check("lu_fb_x0", bus.fb_mux_op, NO_FORWARD_SELECT);
        check("lu_bubble_clear", bus.bubble_op, 0);
        check("lu_stall_cnt", bus.stall_count_op, 1);

        // write x0 then read x0 on both operands
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 15, 0, 0, 0);
        tick();
        check("x0_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("x0_fb", bus.fb_mux_op, NO_FORWARD_SELECT);

        // two producers of x3 back-to-back, then a consumer of x3
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 3, 1, 16, 1, 0, 0);
        tick();
        check("young_fa", bus.fa_mux_op, EX_RESULT_SELECT);
        check("young_fb", bus.fb_mux_op, EX_RESULT_SELECT);

        // lw x7 ; add x10, x7 squashed by a flush in its stall cycle
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 1, 0, 0, 10, 1, 0, 0);
        #1 check("fl_pre_stall", bus.stall_op, 1);
        bus.flush_ip = 1'b1;
        #1 check("fl_stall_cancel", bus.stall_op, 0);
        tick();
        check("fl_bubble", bus.bubble_op, 1);
        check("fl_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("fl_flush_cnt", bus.flush_count_op, 1);
        check("fl_stall_cnt", bus.stall_count_op, 1);
        drive(1, 10, 1, 7, 1, 17, 1, 0, 0);
        #1 check("fl_no_stall", bus.stall_op, 0);
        tick();
        check("fl_squashed_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("fl_load_adv_fb", bus.fb_mux_op, WB_RESULT_SELECT);

        // back-to-back flushes, then a consumer of the squashed x11
        drive(1, 0, 0, 0, 0, 11, 1, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 11, 1, 0, 1);
        tick();
        check("fl2_bubble", bus.bubble_op, 1);
        check("fl2_flush_cnt", bus.flush_count_op, 3);
        drive(1, 11, 1, 11, 1, 18, 1, 0, 0);
        tick();
        check("fl2_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("fl2_fb", bus.fb_mux_op, NO_FORWARD_SELECT);

        // x12 = f(x18) forwards from EX, then reset drops between edges
        drive(1, 18, 1, 0, 0, 12, 1, 0, 0);
        tick();
        check("pre_rst_fa", bus.fa_mux_op, EX_RESULT_SELECT);
        check("pre_rst_bubble", bus.bubble_op, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("async_rst_bubble", bus.bubble_op, 1);
        check("async_rst_stall_cnt", bus.stall_count_op, 0);
        check("async_rst_flush_cnt", bus.flush_count_op, 0);
        drive(1, 12, 1, 0, 0, 19, 1, 0, 0);
        reset = 1'b1;
        tick();
        check("post_rst_fa", bus.fa_mux_op, NO_FORWARD_SELECT);
        check("post_rst_bubble", bus.bubble_op, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
